// File: rtl/lut_seq_ctrl.sv
// lut_seq_ctrl: sequences debounced write/save pulses into memory write
// strobes and a fill pointer, and auto-scans stored entries onto d_out.
module lut_seq_ctrl #(
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_pulse,
  input  logic          save_pulse,
  input  logic          show_reg,
  input  logic [DW-1:0] d_in,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] d_out,
  output logic [AW:0]   count,
  output logic          full,
  output logic          staged,
  output logic          err
);

  localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [AW:0]   DEPTH    = (AW+1)'(2**AW);
  localparam logic [TW-1:0] TIMER_TC = TW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, WRITE, SCAN} state_t;

  state_t        state;
  logic [DW-1:0] staging;
  logic [AW-1:0] wr_ptr;
  logic [TW-1:0] timer;

  // Last valid scan index; only meaningful when count != 0.
  logic [AW:0] last_idx;
  assign last_idx = count - 1'b1;

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      staging   <= '0;
      staged    <= 1'b0;
      wr_ptr    <= '0;
      timer     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_out     <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err    <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          d_out <= staging;
          if (show_reg) begin
            // Scan wins over pulses; dropped pulses are not errors here.
            state    <= SCAN;
            mem_addr <= '0;
            timer    <= '0;
          end else if (write_pulse) begin
            staging <= d_in;
            staged  <= 1'b1;
            d_out   <= d_in;
            if (save_pulse) err <= 1'b1;
          end else if (save_pulse) begin
            if (staged && !full) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= wr_ptr;
              mem_wdata <= staging;
              wr_ptr    <= wr_ptr + 1'b1;
              count     <= count + 1'b1;
              full      <= (count + 1'b1) == DEPTH;
              staged    <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          d_out <= staging;
          if (save_pulse) err <= 1'b1;
          if (show_reg) begin
            state    <= SCAN;
            mem_addr <= '0;
            timer    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          if (!show_reg) begin
            state <= IDLE;
            d_out <= staging;
          end else begin
            d_out <= (count == '0) ? '0 : mem_rdata;
            if (timer == TIMER_TC) begin
              timer <= '0;
              if (count == '0 || {1'b0, mem_addr} == last_idx)
                mem_addr <= '0;
              else
                mem_addr <= mem_addr + 1'b1;
            end else begin
              timer <= timer + 1'b1;
              if (count == '0) mem_addr <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
